// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status bundle for the PS/2 host transmitter.
//   tx_data  [7:0]  byte to send, captured on accept
//   tx_valid        request to send tx_data
//   tx_ready        transmitter idle; tx_valid & tx_ready = accept
//   busy            transfer in progress (receiver must ignore the bus)
//   done            one-cycle end-of-transaction pulse
//   ack_ok          device acknowledged (valid with done, held until next accept)
//   timeout         transfer aborted on device clock timeout (valid with done)
// master = command source, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard with the request-to-send sequence (clock inhibit, data low, release
// clock), frames it with odd parity and stop bit, samples the device ACK and
// reports the outcome. Only low-enables are produced; tri-states live at top.
// Ports:
//   CLK100MHZ    in   system clock
//   RESET        in   synchronous active-high reset
//   tx           slave handshake/status bundle (ps2_host_tx_if)
//   PS2_CLK      in   raw bus clock (asynchronous)
//   PS2_DATA     in   raw bus data (asynchronous)
//   ps2_clk_oe   out  1 = pull PS2_CLK low
//   ps2_data_oe  out  1 = pull PS2_DATA low
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic         CLK100MHZ,
  input  logic         RESET,
  ps2_host_tx_if.slave tx,
  input  logic         PS2_CLK,
  input  logic         PS2_DATA,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, FIN
  } state_t;

  state_t        state, state_n;
  logic [2:0]    clk_s;
  logic [1:0]    data_s;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    sh;
  logic          data_drv;
  logic          ack_smp;
  logic          ack_ok_q;
  logic          timeout_q;
  logic          tmo_abort;

  // clk_s[1:0] is the synchroniser; clk_s[2] holds the previous synced value.
  logic clk_sync, data_sync, fall, tmo_hit;
  assign clk_sync  = clk_s[1];
  assign data_sync = data_s[1];
  assign fall      = clk_s[2] & ~clk_s[1];
  assign tmo_hit   = (cnt == TMO_LAST);

  always_comb begin
    state_n   = state;
    tmo_abort = 1'b0;
    case (state)
      IDLE:    if (tx.tx_valid) state_n = INHIBIT;
      INHIBIT: if (cnt == INH_LAST) state_n = REQ;
      REQ:     if (cnt == SETUP_LAST) state_n = SEND;
      // A device edge on the terminal-count cycle takes priority over timeout.
      SEND: begin
        if (fall) begin
          if (bit_cnt == 4'd9) state_n = ACK;
        end else if (tmo_hit) begin
          state_n   = FIN;
          tmo_abort = 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          state_n = WAIT_IDLE;
        end else if (tmo_hit) begin
          state_n   = FIN;
          tmo_abort = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_n = FIN;
        end else if (tmo_hit) begin
          state_n   = FIN;
          tmo_abort = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      state     <= IDLE;
      clk_s     <= '1;
      data_s    <= '1;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      data_drv  <= 1'b0;
      ack_smp   <= 1'b0;
      ack_ok_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_n;
      clk_s  <= {clk_s[1:0], PS2_CLK};
      data_s <= {data_s[0], PS2_DATA};

      // One counter serves the inhibit/setup timers and the per-edge timeout;
      // it restarts on every state change and, while the device clocks, on every edge.
      if (state_n != state)
        cnt <= '0;
      else if (state == INHIBIT || state == REQ)
        cnt <= cnt + CW'(1);
      else if (state == SEND || state == ACK || state == WAIT_IDLE)
        cnt <= fall ? '0 : cnt + CW'(1);
      else
        cnt <= '0;

      case (state)
        IDLE: begin
          data_drv <= 1'b0;
          if (tx.tx_valid) begin
            sh        <= {1'b1, ~^tx.tx_data, tx.tx_data};
            bit_cnt   <= '0;
            ack_smp   <= 1'b0;
            ack_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        REQ:  if (state_n == SEND) data_drv <= 1'b1;  // start bit
        SEND: begin
          if (fall) begin
            data_drv <= ~sh[0];
            sh       <= {1'b0, sh[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
          end
        end
        ACK:  if (fall) ack_smp <= ~data_sync;
        default: ;
      endcase

      if (tmo_abort) begin
        timeout_q <= 1'b1;
        ack_ok_q  <= 1'b0;
      end else if (state == WAIT_IDLE && state_n == FIN) begin
        timeout_q <= 1'b0;
        ack_ok_q  <= ack_smp;
      end
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2_data_oe = (state == REQ) || ((state == SEND) && data_drv);

  // busy covers every state in which the device may be clocking this transfer,
  // so the receiver can gate its own edge detection with it.
  assign tx.tx_ready = (state == IDLE) && !RESET;
  assign tx.busy     = (state != IDLE) && (state != FIN);
  assign tx.done     = (state == FIN);
  assign tx.ack_ok   = ack_ok_q;
  assign tx.timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a wired-AND PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int SET = 4;
  localparam int TMO = 5000;
  localparam int H   = 20;   // device clock half-period in system cycles

  logic CLK100MHZ = 1'b0;
  logic RESET     = 1'b1;
  logic clk_oe, data_oe;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic bus_clk, bus_data;

  ps2_host_tx_if bus_if ();

  assign bus_clk  = dev_clk  & ~clk_oe;
  assign bus_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .RESET      (RESET),
    .tx         (bus_if),
    .PS2_CLK    (bus_clk),
    .PS2_DATA   (bus_data),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_fall = 0;

  always @(posedge CLK100MHZ) begin
    cyc <= cyc + 1;
    if (bus_if.done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device: wait for request-to-send, then clock nedges falling edges.
  // frame[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  task automatic dev_xfer(input bit ack, input int nedges,
                          output logic [10:0] frame, output int inh, output int req,
                          output bit started);
    frame = '1; inh = 0; req = 0; started = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK100MHZ);
      if (clk_oe && !data_oe) inh++;
      if (clk_oe && data_oe) req++;
      if (bus_clk && !bus_data) begin
        started = 1;
        break;
      end
    end
    if (!started) return;
    frame[0] = bus_data;
    repeat (H) @(negedge CLK100MHZ);
    for (int e = 1; e <= nedges; e++) begin
      if (e == 11) begin
        if (ack) dev_data = 1'b0;
        repeat (H/2) @(negedge CLK100MHZ);
      end
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge CLK100MHZ);
      dev_clk = 1'b1;
      repeat (H/2) @(negedge CLK100MHZ);
      if (e <= 10) frame[e] = bus_data;
      if (e == 11) dev_data = 1'b1;
      repeat (H/2) @(negedge CLK100MHZ);
    end
  endtask

  task automatic host_accept(input logic [7:0] d);
    @(negedge CLK100MHZ);
    bus_if.tx_data  = d;
    bus_if.tx_valid = 1'b1;
    for (int n = 0; n < 50 && !bus_if.tx_ready; n++) @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    bus_if.tx_valid = 1'b0;
    chk("accept_ready_low", 32'(bus_if.tx_ready), 32'd0);
    chk("accept_busy", 32'(bus_if.busy), 32'd1);
  endtask

  task automatic wait_done(input int limit, output bit got, output int at);
    got = 0; at = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK100MHZ);
      if (bus_if.done) begin
        got = 1;
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         nedges;
    logic       parity;
    logic       exp_ack;
    logic       exp_to;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [10:0] frame;
    int inh, req, at;
    bit started, got;
    fork
      dev_xfer(v.ack, v.nedges, frame, inh, req, started);
      begin
        host_accept(v.data);
        wait_done(8000, got, at);
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
          chk("done_ack_ok", 32'(bus_if.ack_ok), 32'(v.exp_ack));
          chk("done_timeout", 32'(bus_if.timeout), 32'(v.exp_to));
          chk("done_oes", {30'd0, clk_oe, data_oe}, 32'd0);
          chk("done_busy", 32'(bus_if.busy), 32'd0);
          @(negedge CLK100MHZ);
          chk("done_one_cycle", 32'(bus_if.done), 32'd0);
          chk("ready_after", 32'(bus_if.tx_ready), 32'd1);
          chk("ack_ok_hold", 32'(bus_if.ack_ok), 32'(v.exp_ack));
          chk("timeout_hold", 32'(bus_if.timeout), 32'(v.exp_to));
        end
      end
    join
    chk("inhibit_cycles", 32'(inh), 32'(INH));
    chk("setup_cycles", 32'(req), 32'(SET));
    chk("start_seen", 32'(started), 32'd1);
    chk("start_bit", 32'(frame[0]), 32'd0);
    if (v.nedges >= 11) begin
      chk("data_byte", 32'(frame[8:1]), 32'(v.data));
      chk("parity_bit", 32'(frame[9]), 32'(v.parity));
      chk("stop_bit", 32'(frame[10]), 32'd1);
    end else begin
      chk("partial_nibble", 32'(frame[4:1]), 32'(v.data[3:0]));
      chk("timeout_window", 32'((at - last_fall >= TMO) && (at - last_fall <= TMO + 10)), 32'd1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [10:0] f1, f2;
    int i1, r1, at1, at2, dc;
    bit s1, g1, g2;

    vecs[0] = '{8'hF4, 1'b1, 11, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hED, 1'b1, 11, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 11, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 11, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 4,  1'b1, 1'b0, 1'b1};

    bus_if.tx_data  = 8'h00;
    bus_if.tx_valid = 1'b0;

    repeat (3) @(negedge CLK100MHZ);
    chk("rst_oes", {30'd0, clk_oe, data_oe}, 32'd0);
    chk("rst_status", {28'd0, bus_if.busy, bus_if.done, bus_if.ack_ok, bus_if.timeout}, 32'd0);
    chk("rst_ready", 32'(bus_if.tx_ready), 32'd0);
    RESET = 1'b0;
    @(negedge CLK100MHZ);
    chk("post_rst_ready", 32'(bus_if.tx_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Request held during a transfer is not queued; it is taken once tx_ready returns.
    dc = done_cnt;
    fork
      begin
        dev_xfer(1'b1, 11, f1, i1, r1, s1);
        dev_xfer(1'b1, 11, f2, i1, r1, s1);
      end
      begin
        host_accept(8'hAA);
        bus_if.tx_data  = 8'h55;
        bus_if.tx_valid = 1'b1;
        wait_done(8000, g1, at1);
        chk("hold_done1", 32'(g1), 32'd1);
        @(negedge CLK100MHZ);
        chk("hold_ready_back", 32'(bus_if.tx_ready), 32'd1);
        @(negedge CLK100MHZ);
        bus_if.tx_valid = 1'b0;
        chk("hold_second_busy", 32'(bus_if.busy), 32'd1);
        wait_done(8000, g2, at2);
        chk("hold_done2", 32'(g2), 32'd1);
      end
    join
    chk("hold_first_byte", 32'(f1[8:1]), 32'h0000_00AA);
    chk("hold_second_byte", 32'(f2[8:1]), 32'h0000_0055);
    repeat (50) @(negedge CLK100MHZ);
    chk("hold_done_count", 32'(done_cnt - dc), 32'd2);

    // Reset mid-transfer after the 6th device edge.
    fork
      dev_xfer(1'b1, 6, f1, i1, r1, s1);
      host_accept(8'hF4);
    join
    dc = done_cnt;
    chk("mid_busy_before_rst", 32'(bus_if.busy), 32'd1);
    RESET = 1'b1;
    @(negedge CLK100MHZ);
    RESET = 1'b0;
    chk("mid_rst_oes", {30'd0, clk_oe, data_oe}, 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_done", 32'(bus_if.done), 32'd0);
    repeat (100) @(negedge CLK100MHZ);
    chk("mid_rst_no_done", 32'(done_cnt - dc), 32'd0);
    chk("mid_rst_ready", 32'(bus_if.tx_ready), 32'd1);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
